ir_prefetch_queue: RTL

// - Parametrised successor to the single-word instruction register.
// - Buffers up to DEPTH instruction words fetched from instruction memory in a FIFO.
// - Moves the head word into the architectural IR when the control unit asserts ir_load (IRWre role).
// - Breaks out MIPS-style fields from the held IR. Sits between instruction memory and the control unit/register file.
//

---
 rtl/ir_pkg.sv | 28 ++
 rtl/ir_fifo.sv | 74 +++++++
 rtl/ir_prefetch_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register prefetch queue.
// Provides MIPS field positions and the queued entry type.
package ir_pkg;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int SA_MSB   = 10;
    localparam int SA_LSB   = 6;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int ADDR_MSB = 25;
    localparam int ADDR_LSB = 0;

    localparam int INS_W = 32;
    localparam int TAG_W = 32;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [TAG_W-1:0] pc;
    } ir_entry_t;

endpackage

// File: rtl/ir_fifo.sv
// Circular FIFO of DEPTH entries, each DW bits wide, with sync clear.
// Ports: CLK, RST (async low), clr_i, push_i, pop_i, wdata_i,
// rdata_o (head, combinational), count_o, full_o, empty_o.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DW-1:0]              wdata_i,
    output logic [DW-1:0]              rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Caller guarantees push only when room (or popping) and pop only
    // when non-empty; guard anyway so the count can never wrap.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted.
    always_ff @(posedge CLK) begin
        if (!clr_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Prefetch queue feeding the architectural IR, with MIPS field slicing.
// Ports: fetch side (in_valid/in_ins/in_pc/in_ready), control
// (ir_load/flush), IR outputs (IRout/ir_pc/ir_valid), fields, q_count.
module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_ins,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   in_ready,
    input  logic                   ir_load,
    input  logic                   flush,
    output logic [WIDTH-1:0]       IRout,
    output logic [PC_W-1:0]        ir_pc,
    output logic                   ir_valid,
    output logic [5:0]             op,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             sa,
    output logic [15:0]            imm16,
    output logic [25:0]            addr26,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int DW = WIDTH + PC_W;

    logic [DW-1:0]    head;
    logic [WIDTH-1:0] head_ins;
    logic [PC_W-1:0]  head_pc;
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;

    logic [WIDTH-1:0] ir_q, ir_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             vld_q, vld_d;

    assign head_ins = head[DW-1:PC_W];
    assign head_pc  = head[PC_W-1:0];

    // A full queue still accepts when the same edge pops the head.
    assign in_ready  = !full || (ir_load && !empty);
    assign push_acc  = in_valid && in_ready;
    // Empty queue plus load: the fetched word goes straight to IR.
    assign bypass    = ir_load && empty && push_acc;
    assign fifo_push = push_acc && !bypass && !flush;
    assign fifo_pop  = ir_load && !empty && !flush;

    ir_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .clr_i   (flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({in_ins, in_pc}),
        .rdata_o (head),
        .count_o (q_count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ir_d  = ir_q;
        pc_d  = pc_q;
        vld_d = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (ir_load) begin
            if (!empty) begin
                ir_d  = head_ins;
                pc_d  = head_pc;
                vld_d = 1'b1;
            end else if (push_acc) begin
                ir_d  = in_ins;
                pc_d  = in_pc;
                vld_d = 1'b1;
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ir_q  <= '0;
            pc_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            vld_q <= vld_d;
        end
    end

    assign IRout    = ir_q;
    assign ir_pc    = pc_q;
    assign ir_valid = vld_q;

    assign op     = IRout[OP_MSB:OP_LSB];
    assign rs     = IRout[RS_MSB:RS_LSB];
    assign rt     = IRout[RT_MSB:RT_LSB];
    assign rd     = IRout[RD_MSB:RD_LSB];
    assign sa     = IRout[SA_MSB:SA_LSB];
    assign imm16  = IRout[IMM_MSB:IMM_LSB];
    assign addr26 = IRout[ADDR_MSB:ADDR_LSB];

endmodule
